result_dispatcher: RTL and testbench

Read-side counterpart to the two-slave arbiter. It pops tagged entries from the shared processing FIFO and routes each one to master port 0 or master port 1, using the source tag the arbiter stored. Delivery uses a valid/ready handshake. After every BURST_LEN delivered beats on a channel it pulses that channel's completion strobe (mstr0_cmplt / mstr1_cmplt), which the arbiter consumes.

---
 rtl/result_dispatcher.sv | 203 ++++++++++++++++++++
 tb/tb_result_dispatcher.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_dispatcher.sv
// ---------------------------------------------------------------------------
// result_dispatcher
//
// Read side of the two-slave arbiter. Pops tagged entries from the shared
// processing FIFO and routes each one to master port 0 or 1 based on the
// source tag that the arbiter stored. Each beat is handed over with a
// valid/ready handshake. After every BURST_LEN accepted beats on a channel,
// that channel's completion strobe pulses for one cycle.
//
// Optional feature macro: DISPATCH_TIMEOUT_EN
//   Defined   : a beat stalled for TIMEOUT cycles is dropped and
//               err_timeout pulses for one cycle.
//   Undefined : SEND waits indefinitely and err_timeout is tied low.
//
// Parameters
//   DW        data word width
//   BURST_LEN accepted beats per channel between completion pulses (>= 2)
//   TIMEOUT   stall limit in cycles (DISPATCH_TIMEOUT_EN only)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   fifo_empty            FIFO holds no entries
//   fifo_rd_en            pop request; the entry is returned one cycle later
//   fifo_rd_data/src/mode/proc_val
//                         popped entry. src selects the master and
//                         mode 2'b00 marks an inactive entry.
//   mstrN_data/mode/proc_val, mstrN_valid
//                         beat delivered to master N
//   mstrN_ready           master N accepts the beat
//   mstrN_cmplt           one-cycle burst-complete pulse
//   err_timeout           one-cycle pulse when a stalled beat is dropped
// ---------------------------------------------------------------------------
module result_dispatcher #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  input  logic          fifo_rd_src,
  input  logic [1:0]    fifo_rd_mode,
  input  logic [7:0]    fifo_rd_proc_val,
  output logic [DW-1:0] mstr0_data,
  output logic [1:0]    mstr0_mode,
  output logic [7:0]    mstr0_proc_val,
  output logic          mstr0_valid,
  input  logic          mstr0_ready,
  output logic          mstr0_cmplt,
  output logic [DW-1:0] mstr1_data,
  output logic [1:0]    mstr1_mode,
  output logic [7:0]    mstr1_proc_val,
  output logic          mstr1_valid,
  input  logic          mstr1_ready,
  output logic          mstr1_cmplt,
  output logic          err_timeout
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          sel_src;     // channel owning the beat held in SEND
  logic          accept;      // selected master takes the beat this cycle
  logic          drop;        // stalled beat abandoned this cycle
  logic          beat_done;   // beat leaves SEND (accepted or dropped)
  logic [CW-1:0] beat_cnt0;
  logic [CW-1:0] beat_cnt1;

  // Valid is always high while in SEND, so the handshake reduces to the
  // ready of the selected channel; ready of the other channel is ignored.
  assign accept    = (state == SEND) && (sel_src ? mstr1_ready : mstr0_ready);
  assign beat_done = accept || drop;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_cnt;
  logic          err_q;

  // The drop fires on the TIMEOUT-th consecutive stalled cycle.
  assign drop        = (state == SEND) && !accept && (stall_cnt == SW'(TIMEOUT - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= drop;
      if ((state == SEND) && !accept && !drop) begin
        stall_cnt <= stall_cnt + SW'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`else
  // TIMEOUT has no role without the stall counter.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign drop           = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pop request. Pops are only issued from IDLE or from the
  // cycle a beat leaves SEND, which keeps at most one pop outstanding.
  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = (fifo_rd_mode == 2'b00) ? IDLE : SEND;
      end
      SEND: begin
        if (beat_done) begin
          fifo_rd_en = !fifo_empty;
          state_next = fifo_empty ? IDLE : FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output registers. Only the selected channel is loaded, so the other
  // channel's fields keep their last value. Inactive entries load nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_src        <= 1'b0;
      mstr0_data     <= '0;
      mstr0_mode     <= '0;
      mstr0_proc_val <= '0;
      mstr0_valid    <= 1'b0;
      mstr1_data     <= '0;
      mstr1_mode     <= '0;
      mstr1_proc_val <= '0;
      mstr1_valid    <= 1'b0;
    end else if ((state == FETCH) && (fifo_rd_mode != 2'b00)) begin
      sel_src <= fifo_rd_src;
      if (fifo_rd_src) begin
        mstr1_data     <= fifo_rd_data;
        mstr1_mode     <= fifo_rd_mode;
        mstr1_proc_val <= fifo_rd_proc_val;
        mstr1_valid    <= 1'b1;
      end else begin
        mstr0_data     <= fifo_rd_data;
        mstr0_mode     <= fifo_rd_mode;
        mstr0_proc_val <= fifo_rd_proc_val;
        mstr0_valid    <= 1'b1;
      end
    end else if (beat_done) begin
      mstr0_valid <= 1'b0;
      mstr1_valid <= 1'b0;
    end
  end

  // Per-channel beat counters. The completion strobe is registered, so it
  // appears in the cycle after the acceptance that completes the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt0   <= '0;
      beat_cnt1   <= '0;
      mstr0_cmplt <= 1'b0;
      mstr1_cmplt <= 1'b0;
    end else begin
      mstr0_cmplt <= accept && !sel_src && (beat_cnt0 == CNT_LAST);
      mstr1_cmplt <= accept &&  sel_src && (beat_cnt1 == CNT_LAST);
      if (accept && !sel_src) begin
        beat_cnt0 <= (beat_cnt0 == CNT_LAST) ? '0 : beat_cnt0 + CW'(1);
      end
      if (accept && sel_src) begin
        beat_cnt1 <= (beat_cnt1 == CNT_LAST) ? '0 : beat_cnt1 + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_result_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_result_dispatcher
//
// Directed bench for result_dispatcher. A small FIFO model returns popped
// entries one cycle after fifo_rd_en. Each scenario task drives stimulus at
// the falling edge and compares DUT outputs there, away from the rising edge.
// Build with or without DISPATCH_TIMEOUT_EN; the timeout scenario adapts.
// ---------------------------------------------------------------------------
module tb_result_dispatcher;

  localparam int DW = 32;
  localparam int BL = 16;
  localparam int TO = 8;
`ifdef DISPATCH_TIMEOUT_EN
  localparam int STALL = 6;
`else
  localparam int STALL = 10;
`endif

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_src;
  logic [1:0]    fifo_rd_mode;
  logic [7:0]    fifo_rd_proc_val;
  logic [DW-1:0] mstr0_data;
  logic [1:0]    mstr0_mode;
  logic [7:0]    mstr0_proc_val;
  logic          mstr0_valid;
  logic          mstr0_ready;
  logic          mstr0_cmplt;
  logic [DW-1:0] mstr1_data;
  logic [1:0]    mstr1_mode;
  logic [7:0]    mstr1_proc_val;
  logic          mstr1_valid;
  logic          mstr1_ready;
  logic          mstr1_cmplt;
  logic          err_timeout;

  result_dispatcher #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_src      (fifo_rd_src),
    .fifo_rd_mode     (fifo_rd_mode),
    .fifo_rd_proc_val (fifo_rd_proc_val),
    .mstr0_data       (mstr0_data),
    .mstr0_mode       (mstr0_mode),
    .mstr0_proc_val   (mstr0_proc_val),
    .mstr0_valid      (mstr0_valid),
    .mstr0_ready      (mstr0_ready),
    .mstr0_cmplt      (mstr0_cmplt),
    .mstr1_data       (mstr1_data),
    .mstr1_mode       (mstr1_mode),
    .mstr1_proc_val   (mstr1_proc_val),
    .mstr1_valid      (mstr1_valid),
    .mstr1_ready      (mstr1_ready),
    .mstr1_cmplt      (mstr1_cmplt),
    .err_timeout      (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [DW-1:0] f_data [0:255];
  logic          f_src  [0:255];
  logic [1:0]    f_mode [0:255];
  logic [7:0]    f_pv   [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data     <= f_data[rd_ptr % 256];
      fifo_rd_src      <= f_src[rd_ptr % 256];
      fifo_rd_mode     <= f_mode[rd_ptr % 256];
      fifo_rd_proc_val <= f_pv[rd_ptr % 256];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // Protocol monitors, inspected at the end of the run.
  int bad_pop    = 0;
  int both_valid = 0;
  always @(negedge clk) begin
    if (fifo_rd_en && fifo_empty) bad_pop = bad_pop + 1;
    if (mstr0_valid && mstr1_valid) both_valid = both_valid + 1;
  end

  int passed = 0;
  int total  = 0;

  // Observation queues filled by drain().
  logic [DW-1:0] got0[$];
  logic [DW-1:0] got1[$];
  int acc0[$];
  int cm0[$];
  int cm1[$];
  int errq[$];
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic src, input logic [1:0] mode,
                      input logic [DW-1:0] d, input logic [7:0] pv);
    f_data[wr_ptr % 256] = d;
    f_src[wr_ptr % 256]  = src;
    f_mode[wr_ptr % 256] = mode;
    f_pv[wr_ptr % 256]   = pv;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Runs ncyc cycles recording acceptances and strobes; no comparisons here.
  task automatic drain(input int ncyc);
    got0.delete(); got1.delete(); acc0.delete();
    cm0.delete(); cm1.delete(); errq.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (mstr0_valid && mstr0_ready) begin
        got0.push_back(mstr0_data);
        acc0.push_back(c);
      end
      if (mstr1_valid && mstr1_ready) got1.push_back(mstr1_data);
      if (mstr0_cmplt) cm0.push_back(c);
      if (mstr1_cmplt) cm1.push_back(c);
      if (err_timeout) errq.push_back(c);
      tick();
    end
  endtask

  function automatic logic [2*DW+25:0] all_outs();
    return {fifo_rd_en, mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_valid,
            mstr0_cmplt, mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_valid,
            mstr1_cmplt, err_timeout};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    mstr0_ready = 1'b0;
    mstr1_ready = 1'b0;
    tick();
    tick();
    total++;
    if (all_outs() !== '0) $display("FAIL reset_outputs: got %0h expected 0", all_outs());
    else passed++;

    rst_n = 1'b1;
    tick();
    push(1'b1, 2'b11, 32'hCAFE_F00D, 8'h33);
    tick();
    tick();
    total++;
    if (mstr1_valid !== 1'b1) $display("FAIL reset_pre_send_valid: got %b expected 1", mstr1_valid);
    else passed++;

    #2 rst_n = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) $display("FAIL reset_async_clear: got %0h expected 0", all_outs());
    else passed++;

    @(negedge clk);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd_en || mstr0_valid || mstr1_valid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) $display("FAIL reset_release_idle: activity %b expected 0", seen);
    else passed++;
  endtask

  task automatic test_single_beat();
    mstr0_ready = 1'b0;
    mstr1_ready = 1'b1;
    push(1'b1, 2'b01, 32'hDEAD_BEEF, 8'h5A);
    #1;
    total++;
    if (fifo_rd_en !== 1'b1) $display("FAIL single_rd_en_c0: got %b expected 1", fifo_rd_en);
    else passed++;
    tick();
    total++;
    if ({mstr1_valid, fifo_rd_en} !== 2'b00)
      $display("FAIL single_fetch_c1: valid,rd_en got %b expected 00", {mstr1_valid, fifo_rd_en});
    else passed++;
    tick();
    total++;
    if (mstr1_valid !== 1'b1) $display("FAIL single_valid_c2: got %b expected 1", mstr1_valid);
    else passed++;
    total++;
    if (mstr1_data !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h expected deadbeef", mstr1_data);
    else passed++;
    total++;
    if ({mstr1_mode, mstr1_proc_val} !== {2'b01, 8'h5A})
      $display("FAIL single_mode_pv: got %h expected 15a", {mstr1_mode, mstr1_proc_val});
    else passed++;
    total++;
    if (mstr0_valid !== 1'b0) $display("FAIL single_other_valid: got %b expected 0", mstr0_valid);
    else passed++;
    tick();
    total++;
    if (mstr1_valid !== 1'b0) $display("FAIL single_valid_drop: got %b expected 0", mstr1_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    int unstable;
    mstr0_ready = 1'b0;
    mstr1_ready = 1'b0;
    push(1'b0, 2'b10, 32'h0123_4567, 8'hA5);
    push(1'b0, 2'b11, 32'h89AB_CDEF, 8'h3C);
    tick();
    tick();
    unstable = 0;
    for (int i = 0; i < STALL; i++) begin
      if (i > 0) tick();
      if (mstr0_valid !== 1'b1 || mstr0_data !== 32'h0123_4567 || mstr0_mode !== 2'b10 ||
          mstr0_proc_val !== 8'hA5 || fifo_rd_en !== 1'b0)
        unstable++;
    end
    total++;
    if (unstable != 0) $display("FAIL bp_hold_stable: unstable cycles %0d expected 0", unstable);
    else passed++;

    mstr0_ready = 1'b1;
    #1;
    total++;
    if (fifo_rd_en !== 1'b1) $display("FAIL bp_pop_on_accept: got %b expected 1", fifo_rd_en);
    else passed++;
    tick();
    total++;
    if (mstr0_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b expected 0", mstr0_valid);
    else passed++;
    tick();
    total++;
    if ({mstr0_valid, mstr0_data, mstr0_mode} !== {1'b1, 32'h89AB_CDEF, 2'b11})
      $display("FAIL bp_second_beat: got %h expected 1_89abcdef_3", {mstr0_valid, mstr0_data, mstr0_mode});
    else passed++;
    tick();
    tick();
    total++;
    if ({fifo_rd_en, mstr0_valid} !== 2'b00)
      $display("FAIL bp_last_beat_idle: rd_en,valid got %b expected 00", {fifo_rd_en, mstr0_valid});
    else passed++;
  endtask

  task automatic test_burst();
    int n1;
    int bad;
    do_reset();
    mstr0_ready = 1'b1;
    mstr1_ready = 1'b1;
    exp0.delete();
    exp1.delete();
    n1 = 0;
    for (int i = 0; i < 37; i++) begin
      if ((i % 4 == 3) && (n1 < 5)) begin
        push(1'b1, 2'b01, 32'h2000 + i, 8'(i));
        exp1.push_back(32'h2000 + i);
        n1++;
      end else begin
        push(1'b0, 2'b01, 32'h1000 + i, 8'(i));
        exp0.push_back(32'h1000 + i);
      end
    end
    drain(100);
    total++;
    if (got0.size() != 32 || got1.size() != 5)
      $display("FAIL burst_beat_counts: got %0d/%0d expected 32/5", got0.size(), got1.size());
    else passed++;
    bad = 0;
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) if (got0[i] !== exp0[i]) bad++;
    for (int i = 0; i < got1.size() && i < exp1.size(); i++) if (got1[i] !== exp1[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL burst_data_order: mismatching beats %0d expected 0", bad);
    else passed++;
    total++;
    if (acc0.size() < 2 || acc0[1] - acc0[0] != 2)
      $display("FAIL burst_throughput: beat spacing not 2 cycles (beats %0d)", acc0.size());
    else passed++;
    total++;
    if (cm0.size() != 2 || acc0.size() != 32)
      $display("FAIL burst_cmplt0_count: got %0d expected 2", cm0.size());
    else passed++;
    total++;
    if (cm0.size() != 2 || acc0.size() != 32 || cm0[0] != acc0[15] + 1 || cm0[1] != acc0[31] + 1)
      $display("FAIL burst_cmplt0_timing: pulses %0d not one cycle after beats 16 and 32", cm0.size());
    else passed++;
    total++;
    if (cm1.size() != 0) $display("FAIL burst_no_cmplt1: got %0d expected 0", cm1.size());
    else passed++;
  endtask

  task automatic test_inactive();
    do_reset();
    mstr0_ready = 1'b1;
    mstr1_ready = 1'b1;
    push(1'b0, 2'b00, 32'hBAD0_BAD0, 8'hFF);
    push(1'b1, 2'b10, 32'h7777_0001, 8'h11);
    tick();
    total++;
    if ({mstr0_valid, mstr1_valid} !== 2'b00)
      $display("FAIL inact_no_valid_c1: got %b expected 00", {mstr0_valid, mstr1_valid});
    else passed++;
    tick();
    total++;
    if ({mstr0_valid, mstr1_valid, fifo_rd_en} !== 3'b001)
      $display("FAIL inact_repop_c2: valid0,valid1,rd_en got %b expected 001", {mstr0_valid, mstr1_valid, fifo_rd_en});
    else passed++;
    tick();
    tick();
    total++;
    if ({mstr1_valid, mstr1_data, mstr1_mode, mstr1_proc_val} !== {1'b1, 32'h7777_0001, 2'b10, 8'h11})
      $display("FAIL inact_next_beat: got %h expected 1_77770001_2_11",
               {mstr1_valid, mstr1_data, mstr1_mode, mstr1_proc_val});
    else passed++;
    tick();

    for (int i = 0; i < 15; i++) push(1'b0, 2'b01, 32'h3000 + i, 8'h00);
    push(1'b0, 2'b00, 32'h3EEE_3EEE, 8'h00);
    push(1'b0, 2'b01, 32'h3100, 8'h00);
    drain(60);
    total++;
    if (got0.size() != 16) $display("FAIL inact_beats: got %0d expected 16", got0.size());
    else passed++;
    total++;
    if (cm0.size() != 1 || acc0.size() != 16 || cm0[0] != acc0[15] + 1)
      $display("FAIL inact_counter_unchanged: cmplt pulses %0d, not one cycle after 16th beat", cm0.size());
    else passed++;
  endtask

  task automatic test_timeout();
`ifdef DISPATCH_TIMEOUT_EN
    int vcnt;
    int errn;
    int errc;
    int last_v;
    do_reset();
    mstr0_ready = 1'b0;
    push(1'b0, 2'b01, 32'h5555_AAAA, 8'h01);
    vcnt = 0; errn = 0; errc = -1; last_v = -1;
    for (int c = 0; c < 40; c++) begin
      if (mstr0_valid) begin
        vcnt++;
        last_v = c;
      end
      if (err_timeout) begin
        errn++;
        errc = c;
      end
      tick();
    end
    total++;
    if (vcnt != TO) $display("FAIL to_stall_len: valid cycles %0d expected %0d", vcnt, TO);
    else passed++;
    total++;
    if (errn != 1 || errc != last_v + 1)
      $display("FAIL to_err_pulse: pulses %0d at %0d expected 1 at %0d", errn, errc, last_v + 1);
    else passed++;
    mstr0_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(1'b0, 2'b01, 32'h4000 + i, 8'h00);
    drain(50);
    total++;
    if (cm0.size() != 1 || acc0.size() != 16 || cm0[0] != acc0[15] + 1)
      $display("FAIL to_beat_not_counted: cmplt pulses %0d, not one cycle after 16th beat", cm0.size());
    else passed++;
    total++;
    if (errq.size() != 0) $display("FAIL to_no_spurious_err: got %0d expected 0", errq.size());
    else passed++;
`else
    int errn;
    do_reset();
    mstr0_ready = 1'b0;
    push(1'b0, 2'b01, 32'h5555_AAAA, 8'h01);
    errn = 0;
    for (int c = 0; c < 1000; c++) begin
      if (err_timeout) errn++;
      tick();
    end
    total++;
    if (mstr0_valid !== 1'b1) $display("FAIL to_waits_forever: valid got %b expected 1", mstr0_valid);
    else passed++;
    total++;
    if (errn != 0) $display("FAIL to_err_tied_low: pulses %0d expected 0", errn);
    else passed++;
    mstr0_ready = 1'b1;
    tick();
    total++;
    if (mstr0_valid !== 1'b0) $display("FAIL to_late_accept: valid got %b expected 0", mstr0_valid);
    else passed++;
`endif
  endtask

  task automatic test_protocol();
    total++;
    if (bad_pop != 0) $display("FAIL proto_pop_when_empty: got %0d expected 0", bad_pop);
    else passed++;
    total++;
    if (both_valid != 0) $display("FAIL proto_one_valid: got %0d expected 0", both_valid);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    mstr0_ready = 1'b0;
    mstr1_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_backpressure();
    test_burst();
    test_inactive();
    test_timeout();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
